// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : EX-stage branch resolution. Evaluates six conditional branch
//                types, drives the same-cycle PC-select, sequences a
//                multi-cycle pipeline flush after a taken branch and keeps
//                saturating conditional/taken branch statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_W      = 16
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               in_valid,
    input  logic               in_stall,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_rs,
    input  logic [WIDTH-1:0]   in_rt,
    input  logic               in_clear_stats,
    output logic               out_cidi_control,
    output logic               out_flush,
    output logic               out_busy,
    output logic [COUNT_W-1:0] out_cond_count,
    output logic [COUNT_W-1:0] out_taken_count
);

    localparam logic [1:0]         c_FLUSH_INIT = 2'(FLUSH_CYCLES);
    localparam logic [COUNT_W-1:0] c_ONE        = COUNT_W'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]         r_state;
    logic [1:0]         r_flush_cnt;
    logic               r_flush;
    logic [COUNT_W-1:0] r_cond_count;
    logic [COUNT_W-1:0] r_taken_count;

    logic w_eq;
    logic w_neg;
    logic w_zero;
    logic w_op_valid;
    logic w_cond;
    logic w_resolve;
    logic w_taken;

    assign w_eq   = (in_rs == in_rt);
    assign w_neg  = in_rs[WIDTH-1];
    assign w_zero = (in_rs == '0);

    // Decode the branch opcode into its condition; 000 and 111 never resolve
    always_comb begin
        w_op_valid = 1'b1;
        w_cond     = 1'b0;
        case (in_op)
            3'b001:  w_cond = w_eq;
            3'b010:  w_cond = !w_eq;
            3'b011:  w_cond = !w_neg;
            3'b100:  w_cond = !w_neg && !w_zero;
            3'b101:  w_cond = w_neg || w_zero;
            3'b110:  w_cond = w_neg;
            default: w_op_valid = 1'b0;
        endcase
    end

    // An instruction arriving while a flush is in progress is being squashed
    assign w_resolve = in_valid && !in_stall && !r_flush && w_op_valid;
    assign w_taken   = w_resolve && w_cond;

    assign out_cidi_control = !w_taken;
    assign out_flush        = r_flush;
    assign out_busy         = r_flush;
    assign out_cond_count   = r_cond_count;
    assign out_taken_count  = r_taken_count;

    // Flush sequencer: counts non-stalled flush cycles down to zero
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 2'd0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_taken) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= c_FLUSH_INIT;
                        r_flush     <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (!in_stall) begin
                        if (r_flush_cnt == 2'd1) begin
                            r_state     <= S_IDLE;
                            r_flush_cnt <= 2'd0;
                            r_flush     <= 1'b0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_flush_cnt <= 2'd0;
                    r_flush     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters; a clear request beats any increment
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cond_count  <= '0;
            r_taken_count <= '0;
        end else if (in_clear_stats) begin
            r_cond_count  <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_resolve && !(&r_cond_count)) begin
                r_cond_count <= r_cond_count + c_ONE;
            end
            if (w_taken && !(&r_taken_count)) begin
                r_taken_count <= r_taken_count + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire
